// File: rtl/map_sel_pkg.sv
// Shared types and constants for the mapper-selection controller.
package map_sel_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      COMMIT = 2'd2
   } state_e;

   localparam logic [3:0] REG_MAPPER   = 4'd0;
   localparam logic [3:0] REG_LAUNCHER = 4'd1;

   localparam int ST_ERR_BIT   = 31;
   localparam int ST_STATE_HI  = 30;
   localparam int ST_STATE_LO  = 29;
   localparam int ST_TMO_BIT   = 28;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
      logic toggle;
   } edge_t;

endpackage

// File: rtl/map_select_ctrl_sync_edge.sv
// N-flop synchroniser with level, rise, fall and toggle indications
// taken from the two oldest flops of the chain.
module sync_edge
   import map_sel_pkg::*;
#(
   parameter int N = 3
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  din,
   output edge_t edges
);

   logic [N-1:0] sync;

   // shift chain, sync[N-1] is the oldest sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[N-2:0], din};
      end
   end

   assign edges.level  = sync[N-2];
   assign edges.rise   = sync[N-2] & ~sync[N-1];
   assign edges.fall   = ~sync[N-2] & sync[N-1];
   assign edges.toggle = sync[N-2] ^ sync[N-1];

endmodule

// File: rtl/map_select_ctrl.sv
// Mapper-selection controller: arms a switch from MCU writes and commits it on the
// CPU reset-vector fetch. Optional switch timeout via `define MAP_SEL_TIMEOUT_EN.
module map_select_ctrl
   import map_sel_pkg::*;
#(
   parameter int          MAP_CNT   = 32,
   parameter int          SEL_W     = $clog2(MAP_CNT),
   parameter int          ARGS_W    = 2,
   parameter int          STATUS_W  = 9,
   parameter int          RST_CNT_W = 8,
   parameter logic [7:0]  VEC_LO    = 8'hFC,
   parameter logic [7:0]  VEC_HI    = 8'hFF,
   parameter int          TMO_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      m2,
   input  logic [7:0]                cpu_data,
   input  logic [SEL_W+5+ARGS_W-1:0] wr_reg,
   input  logic [3:0]                wr_reg_addr,
   input  logic                      wr_reg_changed,
   input  logic [STATUS_W-1:0]       launcher_status,
   output logic [SEL_W-1:0]          select,
   output logic [MAP_CNT-1:0]        map_reset,
   output logic                      cpu_reset,
   output logic [4:0]                chr_off,
   output logic [ARGS_W-1:0]         map_args,
   output logic                      launcher_buffer_num,
   output logic                      launcher_halt,
   output logic                      launcher_load,
   output logic [31:0]               status_reg,
   output logic                      sel_error
);

   edge_t                m2_e;
   edge_t                wr_e;
   logic [7:0]           data_s1, data_s2, cur_byte;
   logic [RST_CNT_W-1:0] rst_cnt;
   state_e               state;
   logic [SEL_W-1:0]     pending_sel;
   logic [SEL_W-1:0]     wr_sel;
   logic [4:0]           wr_chr;
   logic [ARGS_W-1:0]    wr_args;
   logic [31:0]          wr_sel_wide;
   logic [31:0]          status_next;
   logic                 wr_map, wr_lau, sel_oob, vec_match, tmo_hit, tmo_flag;
   logic                 unused_edges;

   sync_edge #(.N(3)) u_m2_sync (.clk(clk), .rst_n(rst_n), .din(m2),             .edges(m2_e));
   sync_edge #(.N(3)) u_wr_sync (.clk(clk), .rst_n(rst_n), .din(wr_reg_changed), .edges(wr_e));

   assign unused_edges = ^{m2_e.level, m2_e.rise, m2_e.toggle, wr_e.level, wr_e.rise, wr_e.fall};

   assign {wr_args, wr_chr, wr_sel} = wr_reg;
   assign wr_sel_wide = 32'(wr_sel);
   assign sel_oob     = (wr_sel_wide >= 32'(MAP_CNT));
   assign cpu_reset   = &rst_cnt;
   assign wr_map      = wr_e.toggle & ~cpu_reset & (wr_reg_addr == REG_MAPPER);
   assign wr_lau      = wr_e.toggle & ~cpu_reset & (wr_reg_addr == REG_LAUNCHER);
   // cur_byte is the capture that shifts to "previous" on this fall
   assign vec_match   = m2_e.fall & (cur_byte == VEC_LO) & (data_s2 == VEC_HI);

   // per-slot reset: every slot but the active one, all of them while stalled
   always_comb begin
      map_reset = '0;
      for (int n = 0; n < MAP_CNT; n++) begin
         map_reset[n] = (SEL_W'(n) != select) | cpu_reset;
      end
   end

   // status word assembled for reload on the next M2 fall
   always_comb begin
      status_next                          = '0;
      status_next[STATUS_W-1:0]            = launcher_status;
      status_next[ST_TMO_BIT]              = tmo_flag;
      status_next[ST_STATE_HI:ST_STATE_LO] = state;
      status_next[ST_ERR_BIT]              = sel_error;
   end

   // data synchroniser, byte capture and M2-stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_s1    <= 8'h00;
         data_s2    <= 8'h00;
         cur_byte   <= 8'h00;
         rst_cnt    <= '0;
         status_reg <= 32'h0000_0000;
      end else begin
         data_s1 <= cpu_data;
         data_s2 <= data_s1;
         if (m2_e.fall) begin
            cur_byte   <= data_s2;
            rst_cnt    <= '0;
            status_reg <= status_next;
         end else if (!cpu_reset) begin
            rst_cnt <= rst_cnt + RST_CNT_W'(1);
         end
      end
   end

   // switch FSM and register-write handling; a mapper write outranks a commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         pending_sel         <= '0;
         select              <= '0;
         chr_off             <= 5'd0;
         map_args            <= '0;
         launcher_buffer_num <= 1'b0;
         launcher_halt       <= 1'b0;
         launcher_load       <= 1'b0;
         sel_error           <= 1'b0;
      end else begin
         launcher_halt <= 1'b0;
         if (wr_map && sel_oob) begin
            sel_error <= 1'b1;
         end
         if (cpu_reset) begin
            state               <= IDLE;
            pending_sel         <= '0;
            select              <= '0;
            chr_off             <= 5'd0;
            map_args            <= '0;
            launcher_buffer_num <= 1'b0;
            launcher_load       <= 1'b0;
         end else begin
            if (wr_lau) begin
               launcher_buffer_num <= wr_reg[0];
               launcher_halt       <= wr_reg[1];
            end
            if (state == COMMIT) begin
               select <= pending_sel;
            end
            if (wr_map) begin
               pending_sel   <= sel_oob ? '0 : wr_sel;
               chr_off       <= wr_chr;
               map_args      <= wr_args;
               state         <= ARMED;
               launcher_load <= 1'b1;
            end else begin
               case (state)
                  IDLE: begin
                     launcher_load <= 1'b0;
                  end
                  ARMED: begin
                     if (vec_match || tmo_hit) begin
                        state         <= COMMIT;
                        launcher_load <= 1'b0;
                     end
                  end
                  COMMIT: begin
                     state <= IDLE;
                  end
                  default: begin
                     state         <= IDLE;
                     launcher_load <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

`ifdef MAP_SEL_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt;

   assign tmo_hit = (state == ARMED) & (&tmo_cnt);

   // counts M2 falls while armed; flag records a commit forced by timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt  <= '0;
         tmo_flag <= 1'b0;
      end else if (cpu_reset) begin
         tmo_cnt <= '0;
      end else if (wr_map) begin
         tmo_cnt  <= '0;
         tmo_flag <= 1'b0;
      end else if (tmo_hit) begin
         tmo_flag <= ~vec_match;
      end else if (state == ARMED && m2_e.fall) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end
`else
   // without the timeout the width parameter has no effect; the flag reads 0
   assign tmo_hit  = 1'b0;
   assign tmo_flag = (TMO_W < 0);
`endif

endmodule

// File: tb/tb_map_select_ctrl.sv
// Directed bench for map_select_ctrl; a second instance with 24 slots exercises out-of-range selects.
module tb_map_select_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m2 = 1'b0;
   logic [7:0]  cpu_data = 8'h00;
   logic [11:0] wr_reg = 12'h000;
   logic [3:0]  wr_reg_addr = 4'd0;
   logic        wr_reg_changed = 1'b0;
   logic [8:0]  launcher_status = 9'h15A;

   logic [4:0]  select, select24;
   logic [31:0] map_reset;
   logic [23:0] map_reset24;
   logic        cpu_reset, cpu_reset24;
   logic [4:0]  chr_off, chr_off24;
   logic [1:0]  map_args, map_args24;
   logic        buf_num, buf_num24, halt, halt24, load, load24, sel_error, sel_error24;
   logic [31:0] status_reg, status_reg24;

   int n_cmp = 0;
   int n_err = 0;
   int h;

   map_select_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_data(cpu_data), .wr_reg(wr_reg),
      .wr_reg_addr(wr_reg_addr), .wr_reg_changed(wr_reg_changed), .launcher_status(launcher_status),
      .select(select), .map_reset(map_reset), .cpu_reset(cpu_reset), .chr_off(chr_off),
      .map_args(map_args), .launcher_buffer_num(buf_num), .launcher_halt(halt),
      .launcher_load(load), .status_reg(status_reg), .sel_error(sel_error)
   );

   map_select_ctrl #(.MAP_CNT(24)) u_dut24 (
      .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_data(cpu_data), .wr_reg(wr_reg),
      .wr_reg_addr(wr_reg_addr), .wr_reg_changed(wr_reg_changed), .launcher_status(launcher_status),
      .select(select24), .map_reset(map_reset24), .cpu_reset(cpu_reset24), .chr_off(chr_off24),
      .map_args(map_args24), .launcher_buffer_num(buf_num24), .launcher_halt(halt24),
      .launcher_load(load24), .status_reg(status_reg24), .sel_error(sel_error24)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic m2_byte(input logic [7:0] b);
      cpu_data = b;
      m2 = 1'b1;
      tick(6);
      m2 = 1'b0;
      tick(6);
   endtask

   task automatic reg_write(input logic [3:0] a, input logic [11:0] p, output int halts);
      wr_reg = p;
      wr_reg_addr = a;
      tick(1);
      wr_reg_changed = ~wr_reg_changed;
      halts = 0;
      repeat (8) begin
         @(negedge clk);
         if (halt) halts++;
      end
   endtask

   initial begin
      tick(3);
      check_val("rst_select", 32'(select), 32'h0);
      check_val("rst_map_reset", map_reset, 32'hFFFF_FFFE);
      check_val("rst_load", 32'(load), 32'h0);
      check_val("rst_cpu_reset", 32'(cpu_reset), 32'h0);
      check_val("rst_status", status_reg, 32'h0);
      rst_n = 1'b1;
      tick(2);

      // asynchronous reset while armed
      reg_write(4'd0, 12'h005, h);
      check_val("armed_load", 32'(load), 32'h1);
      #3 rst_n = 1'b0;
      wr_reg_changed = 1'b0;
      #1 check_val("async_rst_load", 32'(load), 32'h0);
      tick(3);
      rst_n = 1'b1;
      tick(2);
      check_val("post_rst_select", 32'(select), 32'h0);
      check_val("post_rst_load", 32'(load), 32'h0);
      check_val("post_rst_map_reset", map_reset, 32'hFFFF_FFFE);

      // arm slot 3 and commit on FC,FF
      reg_write(4'd0, 12'h483, h);
      check_val("w0_load", 32'(load), 32'h1);
      check_val("w0_chr_off", 32'(chr_off), 32'h4);
      check_val("w0_args", 32'(map_args), 32'h1);
      m2_byte(8'h12);
      check_val("b12_load", 32'(load), 32'h1);
      check_val("b12_select", 32'(select), 32'h0);
      m2_byte(8'hFC);
      check_val("bfc_load", 32'(load), 32'h1);
      m2_byte(8'hFF);
      check_val("commit_select", 32'(select), 32'h3);
      check_val("commit_load", 32'(load), 32'h0);
      check_val("commit_map_reset", map_reset, 32'hFFFF_FFF7);
      check_val("status_armed", status_reg, 32'h2000_015A);
      m2_byte(8'h00);
      check_val("status_idle", status_reg, 32'h0000_015A);

      // M2 stall
      tick(200);
      check_val("stall_early", 32'(cpu_reset), 32'h0);
      tick(70);
      check_val("stall_cpu_reset", 32'(cpu_reset), 32'h1);
      check_val("stall_select", 32'(select), 32'h0);
      check_val("stall_map_reset", map_reset, 32'hFFFF_FFFF);
      reg_write(4'd0, 12'h485, h);
      check_val("stall_wr_load", 32'(load), 32'h0);
      check_val("stall_wr_chr", 32'(chr_off), 32'h0);
      m2_byte(8'h00);
      check_val("unstall_cpu_reset", 32'(cpu_reset), 32'h0);
      check_val("unstall_map_reset", map_reset, 32'hFFFF_FFFE);

      // broken vector sequence must not commit
      reg_write(4'd0, 12'h003, h);
      m2_byte(8'hFC);
      m2_byte(8'h00);
      m2_byte(8'hFF);
      check_val("nomatch_select", 32'(select), 32'h0);
      check_val("nomatch_load", 32'(load), 32'h1);
      m2_byte(8'hFC);
      m2_byte(8'hFF);
      check_val("late_commit_select", 32'(select), 32'h3);

      // launcher register
      reg_write(4'd1, 12'h003, h);
      check_val("halt_pulses", 32'(h), 32'h1);
      check_val("buffer_num_set", 32'(buf_num), 32'h1);
      reg_write(4'd1, 12'h000, h);
      check_val("no_halt_pulse", 32'(h), 32'h0);
      check_val("buffer_num_clr", 32'(buf_num), 32'h0);

      // slot 28: valid for 32 slots, out of range for 24
      reg_write(4'd0, 12'h01C, h);
      check_val("oob_err24", 32'(sel_error24), 32'h1);
      check_val("oob_err32", 32'(sel_error), 32'h0);
      m2_byte(8'h55);
      check_val("oob_status24", status_reg24, 32'hA000_015A);
      check_val("oob_status32", status_reg, 32'h2000_015A);
      m2_byte(8'hFC);
      m2_byte(8'hFF);
      check_val("sel28_select", 32'(select), 32'h1C);
      check_val("sel28_map_reset", map_reset, 32'hEFFF_FFFF);
      check_val("oob_select24", 32'(select24), 32'h0);
      check_val("oob_map_reset24", 32'(map_reset24), 32'h00FF_FFFE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
